// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu. With SEQ_ALU_FLAGS_EXT_EN
// defined the bundle also carries the carry and ovf result flags.
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx, nx, zy, ny, f, no;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
`ifdef SEQ_ALU_FLAGS_EXT_EN
  logic             carry;
  logic             ovf;
`endif

  modport master (
`ifdef SEQ_ALU_FLAGS_EXT_EN
    input  carry, ovf,
`endif
    output in_valid, x, y, zx, nx, zy, ny, f, no, out_ready,
    input  in_ready, out_valid, out, zr, ng
  );

  modport slave (
`ifdef SEQ_ALU_FLAGS_EXT_EN
    output carry, ovf,
`endif
    input  in_valid, x, y, zx, nx, zy, ny, f, no, out_ready,
    output in_ready, out_valid, out, zr, ng
  );
endinterface

// File: rtl/seq_alu.sv
// Digit-serial Hack ALU: WIDTH-bit operation in DIGIT-bit chunks, LSB chunk first.
// Optional macro SEQ_ALU_FLAGS_EXT_EN adds registered carry/ovf result flags.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     abort,
  seq_alu_if.slave bus
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] xs, ys, acc, res, res_nxt;
  logic             f_r, no_r, cy, zacc, zr_r, ng_r;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic [DIGIT-1:0] xk, yk, r_raw, r_out;
  logic [DIGIT:0]   sum;
`ifdef SEQ_ALU_FLAGS_EXT_EN
  logic             carry_r, ovf_r;
`endif

  function automatic logic [WIDTH-1:0] pre_op(input logic [WIDTH-1:0] v,
                                              input logic z, input logic n);
    logic [WIDTH-1:0] t;
    t = z ? '0 : v;
    return n ? ~t : t;
  endfunction

  // Operands are shifted right each RUN cycle, so the live chunk is always at bit 0
  assign xk    = xs[DIGIT-1:0];
  assign yk    = ys[DIGIT-1:0];
  assign sum   = {1'b0, xk} + {1'b0, yk} + {{DIGIT{1'b0}}, cy};
  assign r_raw = f_r ? sum[DIGIT-1:0] : (xk & yk);
  assign r_out = no_r ? ~r_raw : r_raw;
  assign last  = (cnt == CNT_W'(NCHUNK - 1));

  // Result chunks enter from the top so the first chunk ends up at bit 0
  assign res_nxt = (acc >> DIGIT) | (WIDTH'(r_out) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.in_valid)  state_nxt = RUN;
        RUN:     if (last)          state_nxt = DONE;
        DONE:    if (bus.out_ready) state_nxt = IDLE;
        default:                    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs   <= '0;
      ys   <= '0;
      acc  <= '0;
      res  <= '0;
      f_r  <= 1'b0;
      no_r <= 1'b0;
      cy   <= 1'b0;
      zacc <= 1'b0;
      zr_r <= 1'b0;
      ng_r <= 1'b0;
      cnt  <= '0;
`ifdef SEQ_ALU_FLAGS_EXT_EN
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
`endif
    end else if (abort) begin
      cnt <= '0;
      cy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          xs   <= pre_op(bus.x, bus.zx, bus.nx);
          ys   <= pre_op(bus.y, bus.zy, bus.ny);
          f_r  <= bus.f;
          no_r <= bus.no;
          cnt  <= '0;
          cy   <= 1'b0;
          zacc <= 1'b0;
        end
        RUN: begin
          xs   <= xs >> DIGIT;
          ys   <= ys >> DIGIT;
          acc  <= res_nxt;
          cy   <= f_r & sum[DIGIT];
          zacc <= zacc | (|r_out);
          cnt  <= cnt + 1'b1;
          if (last) begin
            cnt  <= '0;
            res  <= res_nxt;
            zr_r <= ~(zacc | (|r_out));
            ng_r <= res_nxt[WIDTH-1];
`ifdef SEQ_ALU_FLAGS_EXT_EN
            // Overflow judged on the raw sum MSB, before the no inversion
            carry_r <= f_r & sum[DIGIT];
            ovf_r   <= f_r & (xk[DIGIT-1] == yk[DIGIT-1]) & (sum[DIGIT-1] != xk[DIGIT-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = res;
  assign bus.zr        = zr_r;
  assign bus.ng        = ng_r;
`ifdef SEQ_ALU_FLAGS_EXT_EN
  assign bus.carry     = carry_r;
  assign bus.ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (16/4 main instance plus 16/1 and 16/16 variants).
// Flag checks compile in when SEQ_ALU_FLAGS_EXT_EN is defined.
module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic abort;
  logic abort_v;

  seq_alu_if #(.WIDTH(16)) bif  ();
  seq_alu_if #(.WIDTH(16)) if1  ();
  seq_alu_if #(.WIDTH(16)) if16 ();

  seq_alu #(.WIDTH(16), .DIGIT(4))  dut   (.clk(clk), .rst_n(rst_n), .abort(abort),   .bus(bif));
  seq_alu #(.WIDTH(16), .DIGIT(1))  dut1  (.clk(clk), .rst_n(rst_n), .abort(abort_v), .bus(if1));
  seq_alu #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .abort(abort_v), .bus(if16));

  int n_tests = 0;
  int n_fail  = 0;

  // ctl = {zx, nx, zy, ny, f, no}
  localparam logic [5:0] C_ADD  = 6'b000010;
  localparam logic [5:0] C_SUB  = 6'b010011;
  localparam logic [5:0] C_NEG1 = 6'b111010;
  localparam logic [5:0] C_ZERO = 6'b101010;
  localparam logic [5:0] C_AND  = 6'b000000;
  localparam logic [5:0] C_NAND = 6'b000001;

  task automatic start_op(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] ctl);
    @(negedge clk);
    bif.x = xv;
    bif.y = yv;
    {bif.zx, bif.nx, bif.zy, bif.ny, bif.f, bif.no} = ctl;
    bif.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
    bif.x = ~xv;
    bif.y = ~yv;
    {bif.zx, bif.nx, bif.zy, bif.ny, bif.f, bif.no} = ~ctl;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bif.out_valid && lat < 40);
  endtask

  task automatic accept_result();
    bif.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bif.in_ready); end
    n_tests++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bif.out_valid); end
    n_tests++; if (bif.out !== 16'h0000) begin n_fail++; $display("FAIL reset_out got=%h exp=0000", bif.out); end
    n_tests++; if (bif.zr !== 1'b0) begin n_fail++; $display("FAIL reset_zr got=%b exp=0", bif.zr); end
    n_tests++; if (bif.ng !== 1'b0) begin n_fail++; $display("FAIL reset_ng got=%b exp=0", bif.ng); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    start_op(16'd5, 16'd3, C_ADD);
    n_tests++; if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL add_busy_in_ready got=%b exp=0", bif.in_ready); end
    wait_done(lat);
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL add_latency got=%0d exp=4", lat); end
    n_tests++; if (bif.out !== 16'h0008) begin n_fail++; $display("FAIL add_out got=%h exp=0008", bif.out); end
    n_tests++; if ({bif.zr, bif.ng} !== 2'b00) begin n_fail++; $display("FAIL add_flags got=%b exp=00", {bif.zr, bif.ng}); end
    accept_result();
  endtask

  task automatic test_sub();
    int lat;
    start_op(16'd3, 16'd5, C_SUB);
    wait_done(lat);
    n_tests++; if (bif.out !== 16'hFFFE) begin n_fail++; $display("FAIL sub_out got=%h exp=fffe", bif.out); end
    n_tests++; if ({bif.zr, bif.ng} !== 2'b01) begin n_fail++; $display("FAIL sub_flags zr_ng got=%b exp=01", {bif.zr, bif.ng}); end
    accept_result();
    start_op(16'h1234, 16'h5678, C_NEG1);
    wait_done(lat);
    n_tests++; if (bif.out !== 16'hFFFF) begin n_fail++; $display("FAIL neg1_out got=%h exp=ffff", bif.out); end
    n_tests++; if ({bif.zr, bif.ng} !== 2'b01) begin n_fail++; $display("FAIL neg1_flags zr_ng got=%b exp=01", {bif.zr, bif.ng}); end
    accept_result();
  endtask

  task automatic test_zero_and();
    int lat;
    start_op(16'hABCD, 16'h1357, C_ZERO);
    wait_done(lat);
    n_tests++; if (bif.out !== 16'h0000) begin n_fail++; $display("FAIL zero_out got=%h exp=0000", bif.out); end
    n_tests++; if ({bif.zr, bif.ng} !== 2'b10) begin n_fail++; $display("FAIL zero_flags zr_ng got=%b exp=10", {bif.zr, bif.ng}); end
    accept_result();
    start_op(16'hF0F0, 16'h3C3C, C_AND);
    wait_done(lat);
    n_tests++; if (bif.out !== 16'h3030) begin n_fail++; $display("FAIL and_out got=%h exp=3030", bif.out); end
    n_tests++; if ({bif.zr, bif.ng} !== 2'b00) begin n_fail++; $display("FAIL and_flags zr_ng got=%b exp=00", {bif.zr, bif.ng}); end
    accept_result();
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(16'h1234, 16'h1111, C_ADD);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({bif.out_valid, bif.in_ready, bif.out, bif.zr, bif.ng} !== {1'b1, 1'b0, 16'h2345, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got v=%b r=%b out=%h zr=%b ng=%b exp v=1 r=0 out=2345 zr=0 ng=0",
                 i, bif.out_valid, bif.in_ready, bif.out, bif.zr, bif.ng);
      end
    end
    accept_result();
    n_tests++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", bif.in_ready); end
    n_tests++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid got=%b exp=0", bif.out_valid); end
    n_tests++; if (bif.out !== 16'h2345) begin n_fail++; $display("FAIL release_out_kept got=%h exp=2345", bif.out); end
  endtask

  task automatic test_ready_during_run();
    int lat;
    bif.out_ready = 1'b1;
    start_op(16'h00FF, 16'h0001, C_ADD);
    wait_done(lat);
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL rdyrun_latency got=%0d exp=4", lat); end
    n_tests++; if (bif.out !== 16'h0100) begin n_fail++; $display("FAIL rdyrun_out got=%h exp=0100", bif.out); end
    @(posedge clk);
    @(negedge clk);
    bif.out_ready = 1'b0;
    n_tests++; if ({bif.in_ready, bif.out_valid} !== 2'b10) begin n_fail++; $display("FAIL rdyrun_idle got rdy_vld=%b exp=10", {bif.in_ready, bif.out_valid}); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(16'h0010, 16'h0020, C_ADD);
    // offer the next op while the first is still in flight; it must be ignored until IDLE
    bif.x = 16'h00FF;
    bif.y = 16'h0F0F;
    {bif.zx, bif.nx, bif.zy, bif.ny, bif.f, bif.no} = C_NAND;
    bif.in_valid = 1'b1;
    wait_done(lat);
    n_tests++; if (bif.out !== 16'h0030) begin n_fail++; $display("FAIL b2b_first_out got=%h exp=0030", bif.out); end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=4", lat); end
    bif.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
    wait_done(lat);
    n_tests++; if (bif.out !== 16'hFFF0) begin n_fail++; $display("FAIL b2b_second_out got=%h exp=fff0", bif.out); end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=4", lat); end
    n_tests++; if (bif.ng !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ng got=%b exp=1", bif.ng); end
    accept_result();
  endtask

  task automatic test_abort();
    int lat;
    logic [15:0] prev;
    logic seen;
    prev = bif.out;
    start_op(16'h1111, 16'h2222, C_ADD);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    n_tests++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready got=%b exp=1", bif.in_ready); end
    n_tests++; if (bif.out !== prev) begin n_fail++; $display("FAIL abort_out_kept got=%h exp=%h", bif.out, prev); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bif.out_valid) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid got=%b exp=0", seen); end
    // abort beats a simultaneous in_valid in IDLE
    bif.x = 16'd7;
    bif.y = 16'd7;
    {bif.zx, bif.nx, bif.zy, bif.ny, bif.f, bif.no} = C_ADD;
    bif.in_valid = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
    abort = 1'b0;
    n_tests++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_vs_valid_in_ready got=%b exp=1", bif.in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bif.out_valid) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_vs_valid_no_result got=%b exp=0", seen); end
    start_op(16'd1, 16'd1, C_ADD);
    wait_done(lat);
    n_tests++; if (bif.out !== 16'h0002) begin n_fail++; $display("FAIL post_abort_out got=%h exp=0002", bif.out); end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL post_abort_latency got=%0d exp=4", lat); end
    accept_result();
  endtask

  task automatic test_async_reset();
    start_op(16'h8000, 16'h0001, C_ADD);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready got=%b exp=1", bif.in_ready); end
    n_tests++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got=%b exp=0", bif.out_valid); end
    n_tests++; if (bif.out !== 16'h0000) begin n_fail++; $display("FAIL arst_out got=%h exp=0000", bif.out); end
    n_tests++; if ({bif.zr, bif.ng} !== 2'b00) begin n_fail++; $display("FAIL arst_flags got=%b exp=00", {bif.zr, bif.ng}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_result got=%b exp=0", bif.out_valid); end
  endtask

  task automatic test_digit_variants();
    int cyc, lat1, lat16;
    logic [15:0] o1, o16;
    logic ng1, ng16;
`ifdef SEQ_ALU_FLAGS_EXT_EN
    logic c1, c16, v1, v16;
    c1 = 1'b1; c16 = 1'b1; v1 = 1'b0; v16 = 1'b0;
`endif
    o1 = 'x; o16 = 'x; ng1 = 1'bx; ng16 = 1'bx;
    @(negedge clk);
    if1.x = 16'h7FFF;  if1.y = 16'h0001;  if1.f = 1'b1;  if1.in_valid = 1'b1;
    if16.x = 16'h7FFF; if16.y = 16'h0001; if16.f = 1'b1; if16.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.in_valid = 1'b0;
    if16.in_valid = 1'b0;
    if1.x = 16'h0;
    if16.x = 16'h0;
    cyc = 0; lat1 = 0; lat16 = 0;
    while ((lat1 == 0 || lat16 == 0) && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (if1.out_valid && lat1 == 0) begin
        lat1 = cyc; o1 = if1.out; ng1 = if1.ng;
`ifdef SEQ_ALU_FLAGS_EXT_EN
        c1 = if1.carry; v1 = if1.ovf;
`endif
      end
      if (if16.out_valid && lat16 == 0) begin
        lat16 = cyc; o16 = if16.out; ng16 = if16.ng;
`ifdef SEQ_ALU_FLAGS_EXT_EN
        c16 = if16.carry; v16 = if16.ovf;
`endif
      end
    end
    n_tests++; if (lat1 != 16) begin n_fail++; $display("FAIL d1_latency got=%0d exp=16", lat1); end
    n_tests++; if (lat16 != 1) begin n_fail++; $display("FAIL d16_latency got=%0d exp=1", lat16); end
    n_tests++; if ({o1, ng1} !== {16'h8000, 1'b1}) begin n_fail++; $display("FAIL d1_out got=%h ng=%b exp=8000 ng=1", o1, ng1); end
    n_tests++; if ({o16, ng16} !== {16'h8000, 1'b1}) begin n_fail++; $display("FAIL d16_out got=%h ng=%b exp=8000 ng=1", o16, ng16); end
`ifdef SEQ_ALU_FLAGS_EXT_EN
    n_tests++; if ({c1, v1} !== 2'b01) begin n_fail++; $display("FAIL d1_carry_ovf got=%b exp=01", {c1, v1}); end
    n_tests++; if ({c16, v16} !== 2'b01) begin n_fail++; $display("FAIL d16_carry_ovf got=%b exp=01", {c16, v16}); end
`endif
  endtask

`ifdef SEQ_ALU_FLAGS_EXT_EN
  task automatic test_flags();
    int lat;
    start_op(16'h7FFF, 16'h0001, C_ADD);
    wait_done(lat);
    n_tests++; if (bif.out !== 16'h8000) begin n_fail++; $display("FAIL ovf_out got=%h exp=8000", bif.out); end
    n_tests++; if ({bif.carry, bif.ovf, bif.ng} !== 3'b011) begin n_fail++; $display("FAIL ovf_flags carry_ovf_ng got=%b exp=011", {bif.carry, bif.ovf, bif.ng}); end
    accept_result();
    start_op(16'hFFFF, 16'h0001, C_ADD);
    wait_done(lat);
    n_tests++; if (bif.out !== 16'h0000) begin n_fail++; $display("FAIL carry_out got=%h exp=0000", bif.out); end
    n_tests++; if ({bif.carry, bif.ovf, bif.zr} !== 3'b101) begin n_fail++; $display("FAIL carry_flags carry_ovf_zr got=%b exp=101", {bif.carry, bif.ovf, bif.zr}); end
    accept_result();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0;
    abort = 1'b0;
    abort_v = 1'b0;
    bif.in_valid = 1'b0; bif.out_ready = 1'b0; bif.x = '0; bif.y = '0;
    {bif.zx, bif.nx, bif.zy, bif.ny, bif.f, bif.no} = '0;
    if1.in_valid = 1'b0; if1.out_ready = 1'b1; if1.x = '0; if1.y = '0;
    {if1.zx, if1.nx, if1.zy, if1.ny, if1.f, if1.no} = '0;
    if16.in_valid = 1'b0; if16.out_ready = 1'b1; if16.x = '0; if16.y = '0;
    {if16.zx, if16.nx, if16.zy, if16.ny, if16.f, if16.no} = '0;

    test_reset();
    test_add();
    test_sub();
    test_zero_and();
    test_backpressure();
    test_ready_during_run();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_digit_variants();
`ifdef SEQ_ALU_FLAGS_EXT_EN
    test_flags();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
